// File: rtl/compare_timer.sv
// compare_timer: multi-channel timer/compare unit.
//   An N-bit up-counter runs from 0 to a programmable terminal count (period),
//   either wrapping (periodic) or stopping (one-shot). CHANNELS compare
//   registers each drive a sticky match flag and a PWM output. Comparisons are
//   done by subtract-with-borrow against the counter.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   en, start, mode        count enable, restart, 0=periodic / 1=one-shot
//   period_we, period_in   period register write
//   cmp_we, cmp_sel, cmp_in  compare register write (sel >= CHANNELS ignored)
//   flag_clr               per-channel match flag clear
//   count, running, wrap   counter value, active flag, terminal pulse
//   match, pwm, irq        sticky flags, count < cmp[i] (registered), |match
module compare_timer #(
  parameter int N        = 12,
  parameter int CHANNELS = 2,
  localparam int SW      = ($clog2(CHANNELS) > 0) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                start,
  input  logic                mode,
  input  logic                period_we,
  input  logic [N-1:0]        period_in,
  input  logic                cmp_we,
  input  logic [SW-1:0]       cmp_sel,
  input  logic [N-1:0]        cmp_in,
  input  logic [CHANNELS-1:0] flag_clr,
  output logic [N-1:0]        count,
  output logic                running,
  output logic                wrap,
  output logic [CHANNELS-1:0] match,
  output logic [CHANNELS-1:0] pwm,
  output logic                irq
);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } run_state_e;

  run_state_e                 state_q, state_d;
  logic [N-1:0]               count_q, count_d;
  logic [N-1:0]               period_q, period_d;
  logic [CHANNELS-1:0][N-1:0] cmp_q, cmp_d;
  logic                       wrap_q, wrap_d;
  logic [CHANNELS-1:0]        match_q, match_d;
  logic [CHANNELS-1:0]        pwm_q, pwm_d;

  logic                       term;
  logic                       active;
  logic [CHANNELS-1:0][N:0]   cmp_diff;

  // Terminal when count - period does not borrow, i.e. count >= period. Using
  // >= rather than == lets a period lowered below the current count still end
  // the cycle instead of running on to 2^N.
  assign term   = ~1'(({1'b0, count_q} - {1'b0, period_q}) >> N);
  assign active = en && (state_q == ST_RUNNING);

  // Per-channel count - cmp[i]: top bit is the borrow (count < cmp), the low
  // bits are zero exactly on equality.
  always_comb begin
    cmp_diff = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cmp_diff[i] = {1'b0, count_q} - {1'b0, cmp_q[i]};
    end
  end

  // Counter, run state and wrap pulse. start overrides any advance.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    if (start) begin
      count_d = '0;
      state_d = ST_RUNNING;
    end else if (active) begin
      if (!term) begin
        count_d = count_q + N'(1);
      end else begin
        wrap_d = 1'b1;
        if (mode) begin
          state_d = ST_STOPPED;
        end else begin
          count_d = '0;
        end
      end
    end
  end

  // Register writes; compares this cycle still see the old values.
  always_comb begin
    period_d = period_q;
    cmp_d    = cmp_q;
    if (period_we) begin
      period_d = period_in;
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cmp_we && (cmp_sel == SW'(i))) begin
        cmp_d[i] = cmp_in;
      end
    end
  end

  // Match flags: set beats clear. PWM is sampled every cycle regardless of en.
  always_comb begin
    match_d = match_q;
    pwm_d   = pwm_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      match_d[i] = (match_q[i] & ~flag_clr[i]) |
                   (active & (cmp_diff[i][N-1:0] == '0));
      pwm_d[i]   = cmp_diff[i][N];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUNNING;
      count_q  <= '0;
      period_q <= '1;
      cmp_q    <= '0;
      wrap_q   <= 1'b0;
      match_q  <= '0;
      pwm_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      cmp_q    <= cmp_d;
      wrap_q   <= wrap_d;
      match_q  <= match_d;
      pwm_q    <= pwm_d;
    end
  end

  assign count   = count_q;
  assign running = (state_q == ST_RUNNING);
  assign wrap    = wrap_q;
  assign match   = match_q;
  assign pwm     = pwm_q;
  assign irq     = |match_q;

endmodule

// File: tb/tb_compare_timer.sv
// Scoreboard bench for compare_timer (N=12, CHANNELS=2). Stimulus pushes the
// hand-computed post-edge output state into a queue tagged with its sample
// time; an independent monitor samples 1 time unit after each rising clock or
// reset edge and pops/compares every entry that has come due.
module tb_compare_timer;

  localparam bit [4:0] M_CNT  = 5'd1;
  localparam bit [4:0] M_RUN  = 5'd2;
  localparam bit [4:0] M_WRAP = 5'd4;
  localparam bit [4:0] M_MT   = 5'd8;
  localparam bit [4:0] M_PWM  = 5'd16;
  localparam bit [4:0] M_ALL  = 5'd31;

  logic        clk;
  logic        rst;
  logic        en;
  logic        start;
  logic        mode;
  logic        period_we;
  logic [11:0] period_in;
  logic        cmp_we;
  logic        cmp_sel;
  logic [11:0] cmp_in;
  logic [1:0]  flag_clr;
  logic [11:0] count;
  logic        running;
  logic        wrap;
  logic [1:0]  match;
  logic [1:0]  pwm;
  logic        irq;

  typedef struct {
    time         due;
    string       nm;
    bit [4:0]    m;
    logic [11:0] c;
    logic        r;
    logic        w;
    logic [1:0]  mt;
    logic [1:0]  p;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;

  logic [11:0] t2_cnt  [13] = '{1, 2, 3, 4, 5, 0, 1, 2, 3, 4, 5, 0, 1};
  logic        t2_wrap [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};

  compare_timer #(.N(12), .CHANNELS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .start    (start),
    .mode     (mode),
    .period_we(period_we),
    .period_in(period_in),
    .cmp_we   (cmp_we),
    .cmp_sel  (cmp_sel),
    .cmp_in   (cmp_in),
    .flag_clr (flag_clr),
    .count    (count),
    .running  (running),
    .wrap     (wrap),
    .match    (match),
    .pwm      (pwm),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void expect_at(input time due, input string nm, input bit [4:0] m,
                                    input logic [11:0] c, input logic r, input logic w,
                                    input logic [1:0] mt, input logic [1:0] p);
    exp_t e;
    e.due = due; e.nm = nm; e.m = m; e.c = c; e.r = r; e.w = w; e.mt = mt; e.p = p;
    scb.push_back(e);
  endfunction

  // Called at a falling edge with inputs set; expectation is for the state
  // after the next rising edge. One-cycle strobes are dropped afterwards.
  task automatic step(input string nm, input bit [4:0] m, input logic [11:0] c,
                      input logic r, input logic w, input logic [1:0] mt, input logic [1:0] p);
    if (m != 5'd0) expect_at($time + 6, nm, m, c, r, w, mt, p);
    @(negedge clk);
    start     = 1'b0;
    period_we = 1'b0;
    cmp_we    = 1'b0;
    flag_clr  = 2'b00;
  endtask

  // Monitor
  initial begin
    exp_t e;
    bit   ok;
    forever begin
      @(posedge clk or posedge rst);
      #1;
      while (scb.size() != 0 && scb[0].due <= $time) begin
        e  = scb.pop_front();
        ok = 1'b1;
        if (e.m[0] && (count !== e.c)) ok = 1'b0;
        if (e.m[1] && (running !== e.r)) ok = 1'b0;
        if (e.m[2] && (wrap !== e.w)) ok = 1'b0;
        if (e.m[3] && ((match !== e.mt) || (irq !== (|e.mt)))) ok = 1'b0;
        if (e.m[4] && (pwm !== e.p)) ok = 1'b0;
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL %s @%0t (mask %b): got count=%0d running=%b wrap=%b match=%b irq=%b pwm=%b, expected count=%0d running=%b wrap=%b match=%b irq=%b pwm=%b",
                   e.nm, $time, e.m, count, running, wrap, match, irq, pwm,
                   e.c, e.r, e.w, e.mt, |e.mt, e.p);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; start = 1'b0; mode = 1'b0;
    period_we = 1'b0; period_in = '0; cmp_we = 1'b0; cmp_sel = 1'b0;
    cmp_in = '0; flag_clr = 2'b00;
    @(negedge clk);
    step("reset_init", M_ALL, 12'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    rst = 1'b0;

    // 1: count to 37 with match[0] set, then asynchronous reset mid-cycle
    cmp_we = 1'b1; cmp_sel = 1'b1; cmp_in = 12'd100;
    step("t1_cmp1_wr", M_CNT | M_MT | M_PWM, 12'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    cmp_we = 1'b1; cmp_sel = 1'b0; cmp_in = 12'd36;
    step("t1_cmp0_wr", M_CNT | M_MT | M_PWM, 12'd0, 1'b1, 1'b0, 2'b00, 2'b10);
    en = 1'b1;
    for (int i = 1; i <= 37; i++) begin
      if (i == 37) step("t1_at37", M_ALL, 12'd37, 1'b1, 1'b0, 2'b01, 2'b10);
      else         step("t1_count", M_CNT, 12'(i), 1'b1, 1'b0, 2'b00, 2'b00);
    end
    en = 1'b0;
    #2;
    expect_at($time + 1, "t1_async_rst", M_ALL, 12'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 2: periodic, period 5
    period_we = 1'b1; period_in = 12'd5; mode = 1'b0;
    step("t2_per_wr", M_CNT | M_RUN | M_WRAP | M_PWM, 12'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    en = 1'b1;
    for (int i = 0; i < 13; i++)
      step("t2_periodic", M_CNT | M_RUN | M_WRAP | M_PWM, t2_cnt[i], 1'b1, t2_wrap[i], 2'b00, 2'b00);

    // 3: one-shot, period 3
    start = 1'b1; period_we = 1'b1; period_in = 12'd3; mode = 1'b1;
    step("t3_start", M_CNT | M_RUN | M_WRAP | M_PWM, 12'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t3_os", M_CNT | M_RUN | M_WRAP, 12'd1, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t3_os", M_CNT | M_RUN | M_WRAP, 12'd2, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t3_os", M_CNT | M_RUN | M_WRAP, 12'd3, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t3_term", M_CNT | M_RUN | M_WRAP, 12'd3, 1'b0, 1'b1, 2'b00, 2'b00);
    step("t3_hold", M_CNT | M_RUN | M_WRAP, 12'd3, 1'b0, 1'b0, 2'b00, 2'b00);
    step("t3_hold", M_CNT | M_RUN | M_WRAP, 12'd3, 1'b0, 1'b0, 2'b00, 2'b00);
    start = 1'b1;
    step("t3_restart", M_CNT | M_RUN | M_WRAP, 12'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t3_run", M_CNT | M_RUN | M_WRAP, 12'd1, 1'b1, 1'b0, 2'b00, 2'b00);

    // 4: match / clear with cmp[1]=2, period 7 (cmp[0]=9 > period)
    en = 1'b0; mode = 1'b0; cmp_we = 1'b1; cmp_sel = 1'b0; cmp_in = 12'd9; flag_clr = 2'b11;
    step("t4_setup", M_ALL, 12'd1, 1'b1, 1'b0, 2'b00, 2'b00);
    en = 1'b1; start = 1'b1; period_we = 1'b1; period_in = 12'd7;
    cmp_we = 1'b1; cmp_sel = 1'b1; cmp_in = 12'd2;
    step("t4_start", M_ALL, 12'd0, 1'b1, 1'b0, 2'b00, 2'b01);
    step("t4_e1",  M_ALL, 12'd1, 1'b1, 1'b0, 2'b00, 2'b11);
    step("t4_e2",  M_ALL, 12'd2, 1'b1, 1'b0, 2'b00, 2'b11);
    step("t4_set", M_ALL, 12'd3, 1'b1, 1'b0, 2'b10, 2'b01);
    step("t4_e4",  M_ALL, 12'd4, 1'b1, 1'b0, 2'b10, 2'b01);
    step("t4_e5",  M_ALL, 12'd5, 1'b1, 1'b0, 2'b10, 2'b01);
    step("t4_e6",  M_ALL, 12'd6, 1'b1, 1'b0, 2'b10, 2'b01);
    step("t4_e7",  M_ALL, 12'd7, 1'b1, 1'b0, 2'b10, 2'b01);
    step("t4_wrap", M_ALL, 12'd0, 1'b1, 1'b1, 2'b10, 2'b01);
    step("t4_e9",  M_ALL, 12'd1, 1'b1, 1'b0, 2'b10, 2'b11);
    step("t4_e10", M_ALL, 12'd2, 1'b1, 1'b0, 2'b10, 2'b11);
    flag_clr = 2'b10;
    step("t4_set_wins", M_ALL, 12'd3, 1'b1, 1'b0, 2'b10, 2'b01);
    flag_clr = 2'b10;
    step("t4_clear", M_ALL, 12'd4, 1'b1, 1'b0, 2'b00, 2'b01);

    // 5: PWM with cmp[0]=4, period 7: pwm[0] high for counts 0..3
    cmp_we = 1'b1; cmp_sel = 1'b0; cmp_in = 12'd4;
    step("t5_cmp_wr", M_ALL, 12'd5, 1'b1, 1'b0, 2'b00, 2'b01);
    step("t5_pwm", M_ALL, 12'd6, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t5_pwm", M_ALL, 12'd7, 1'b1, 1'b0, 2'b00, 2'b00);
    step("t5_pwm", M_ALL, 12'd0, 1'b1, 1'b1, 2'b00, 2'b00);
    step("t5_pwm", M_ALL, 12'd1, 1'b1, 1'b0, 2'b00, 2'b11);
    step("t5_pwm", M_ALL, 12'd2, 1'b1, 1'b0, 2'b00, 2'b11);
    step("t5_pwm", M_ALL, 12'd3, 1'b1, 1'b0, 2'b10, 2'b01);
    step("t5_pwm", M_ALL, 12'd4, 1'b1, 1'b0, 2'b10, 2'b01);
    step("t5_pwm", M_ALL, 12'd5, 1'b1, 1'b0, 2'b11, 2'b00);
    step("t5_pwm", M_ALL, 12'd6, 1'b1, 1'b0, 2'b11, 2'b00);
    step("t5_pwm", M_ALL, 12'd7, 1'b1, 1'b0, 2'b11, 2'b00);
    step("t5_pwm", M_ALL, 12'd0, 1'b1, 1'b1, 2'b11, 2'b00);
    step("t5_pwm", M_ALL, 12'd1, 1'b1, 1'b0, 2'b11, 2'b11);

    // 6: period shrink below count, then full-range wrap 4095 -> 0
    period_we = 1'b1; period_in = 12'd4095; flag_clr = 2'b11;
    step("t6_per_max", M_ALL, 12'd2, 1'b1, 1'b0, 2'b00, 2'b11);
    for (int i = 3; i <= 10; i++)
      step("t6_up", M_CNT | M_WRAP, 12'(i), 1'b1, 1'b0, 2'b00, 2'b00);
    en = 1'b0; period_we = 1'b1; period_in = 12'd6;
    step("t6_shrink_wr", M_CNT | M_RUN | M_WRAP, 12'd10, 1'b1, 1'b0, 2'b00, 2'b00);
    en = 1'b1;
    step("t6_shrink_wrap", M_CNT | M_RUN | M_WRAP, 12'd0, 1'b1, 1'b1, 2'b00, 2'b00);
    step("t6_after", M_CNT | M_RUN | M_WRAP, 12'd1, 1'b1, 1'b0, 2'b00, 2'b00);
    en = 1'b0; period_we = 1'b1; period_in = 12'd4095;
    step("t6_per_4095", M_CNT | M_RUN | M_WRAP, 12'd1, 1'b1, 1'b0, 2'b00, 2'b00);
    en = 1'b1;
    for (int i = 0; i < 4094; i++) begin
      if (i == 4093) step("t6_at4095", M_CNT | M_RUN | M_WRAP, 12'd4095, 1'b1, 1'b0, 2'b00, 2'b00);
      else           step("t6_run", 5'd0, 12'd0, 1'b1, 1'b0, 2'b00, 2'b00);
    end
    step("t6_wrap4095", M_CNT | M_RUN | M_WRAP, 12'd0, 1'b1, 1'b1, 2'b00, 2'b00);
    step("t6_after4095", M_CNT | M_RUN | M_WRAP, 12'd1, 1'b1, 1'b0, 2'b00, 2'b00);

    en = 1'b0;
    repeat (3) @(negedge clk);
    if (scb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries pending, expected 0", scb.size());
      errors += scb.size();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
